// File: rtl/x_quant_stream.sv
// Streaming input quantizer: shift (optionally rounded) then saturate to W_X bits, two-stage valid/ready pipeline.
// Define QUANT_ROUND_EN to add a round-half-up offset before the shift; the default build floors.
module x_quant_stream #(
  parameter int W_IN  = 8,
  parameter int W_X   = 4,
  parameter int SHIFT = 4,
  parameter int W_CNT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [W_IN-1:0]  x_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [W_X-1:0]   xq,
  output logic                    sat,
  input  logic                    sat_clr,
  output logic        [W_CNT-1:0] sat_cnt
);

  localparam int WS = W_IN + 1;

`ifdef QUANT_ROUND_EN
  localparam logic signed [WS-1:0] RND = WS'(1 << (SHIFT - 1));
`else
  localparam logic signed [WS-1:0] RND = '0;
`endif

  localparam logic signed [WS-1:0] X_MAX   = WS'((1 << (W_X - 1)) - 1);
  localparam logic signed [WS-1:0] X_MIN   = ~X_MAX;
  localparam logic [W_CNT-1:0]     CNT_MAX = '1;

  logic signed [WS-1:0]  s1_q, s1_d;
  logic                  s1_valid_q;
  logic signed [W_X-1:0] xq_q, xq_d;
  logic                  sat_q, sat_d;
  logic                  out_valid_q;
  logic [W_CNT-1:0]      cnt_q, cnt_d;
  logic                  s2_load, s1_advance, s1_load, out_xfer;

  // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
  always_comb begin
    s2_load    = !out_valid_q || out_ready;
    s1_advance = s1_valid_q && s2_load;
    s1_load    = !s1_valid_q || s1_advance;
    out_xfer   = out_valid_q && out_ready;

    // One extra bit of headroom keeps x_in + RND from overflowing.
    s1_d = ($signed({x_in[W_IN-1], x_in}) + RND) >>> SHIFT;

    xq_d  = s1_q[W_X-1:0];
    sat_d = 1'b0;
    if (s1_q > X_MAX) begin
      xq_d  = X_MAX[W_X-1:0];
      sat_d = 1'b1;
    end else if (s1_q < X_MIN) begin
      xq_d  = X_MIN[W_X-1:0];
      sat_d = 1'b1;
    end

    cnt_d = cnt_q;
    if (sat_clr) begin
      cnt_d = '0;
    end else if (out_xfer && sat_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      xq_q        <= '0;
      sat_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_q <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_load) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          xq_q  <= xq_d;
          sat_q <= sat_d;
        end
      end
      cnt_q <= cnt_d;
    end
  end

  assign in_ready  = s1_load;
  assign out_valid = out_valid_q;
  assign xq        = xq_q;
  assign sat       = sat_q;
  assign sat_cnt   = cnt_q;

endmodule

// File: tb/tb_x_quant_stream.sv
// Self-checking bench for x_quant_stream: directed scenarios plus random traffic against an arithmetic model.
// Instance a uses the default parameters; instance b (SHIFT=2, W_CNT=4) saturates readily to exercise the counter.
module tb_x_quant_stream;

`ifdef QUANT_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, out_ready, sat_clr;
  logic [7:0]  x_in;
  logic        in_ready_a, out_valid_a, sat_a;
  logic [3:0]  xq_a;
  logic [15:0] sat_cnt_a;
  logic        in_ready_b, out_valid_b, sat_b;
  logic [3:0]  xq_b;
  logic [3:0]  sat_cnt_b;

  x_quant_stream #(.W_IN(8), .W_X(4), .SHIFT(4), .W_CNT(16)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .x_in(x_in),
    .out_valid(out_valid_a), .out_ready(out_ready), .xq(xq_a), .sat(sat_a),
    .sat_clr(sat_clr), .sat_cnt(sat_cnt_a)
  );

  x_quant_stream #(.W_IN(8), .W_X(4), .SHIFT(2), .W_CNT(4)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .x_in(x_in),
    .out_valid(out_valid_b), .out_ready(out_ready), .xq(xq_b), .sat(sat_b),
    .sat_clr(sat_clr), .sat_cnt(sat_cnt_b)
  );

  int checks = 0;
  int errors = 0;
  int q[$];
  int cnt_a_m = 0;
  int cnt_b_m = 0;
  bit accepted;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: floor((x + R) / 2^shift), then clip to the signed 4-bit range.
  function automatic int quant(input int x, input int shift, output bit s);
    int d, v, f;
    d = 1 << shift;
    v = x + (ROUND ? d / 2 : 0);
    f = (v >= 0) ? v / d : -((-v + d - 1) / d);
    s = 1'b0;
    if (f > 7)  begin f = 7;  s = 1'b1; end
    if (f < -8) begin f = -8; s = 1'b1; end
    return f;
  endfunction

  task automatic cycle(input bit iv, input int x, input bit ordy, input bit clr);
    bit oxa, sa, sb;
    int ea, eb;
    sa = 1'b0;
    sb = 1'b0;
    in_valid  = iv;
    x_in      = 8'(x);
    out_ready = ordy;
    sat_clr   = clr;
    #1;
    check("in_ready_a", {31'b0, in_ready_a}, {31'b0, (q.size() < 2) || ordy});
    check("in_ready_b", {31'b0, in_ready_b}, {31'b0, (q.size() < 2) || ordy});
    accepted = iv && in_ready_a;
    if (q.size() == 0) begin
      check("idle_valid_a", {31'b0, out_valid_a}, 32'd0);
      check("idle_valid_b", {31'b0, out_valid_b}, 32'd0);
    end
    oxa = out_valid_a && ordy && (q.size() > 0);
    if (oxa) begin
      ea = quant(q[0], 4, sa);
      eb = quant(q[0], 2, sb);
      check("xq_a",        {28'b0, xq_a},        {28'b0, 4'(ea)});
      check("sat_a",       {31'b0, sat_a},       {31'b0, sa});
      check("out_valid_b", {31'b0, out_valid_b}, 32'd1);
      check("xq_b",        {28'b0, xq_b},        {28'b0, 4'(eb)});
      check("sat_b",       {31'b0, sat_b},       {31'b0, sb});
    end
    if (clr) cnt_a_m = 0;
    else if (oxa && sa && cnt_a_m < 65535) cnt_a_m++;
    if (clr) cnt_b_m = 0;
    else if (oxa && sb && cnt_b_m < 15) cnt_b_m++;
    @(posedge clk);
    #1;
    if (oxa) void'(q.pop_front());
    if (accepted) q.push_back(x);
    check("sat_cnt_a", {16'b0, sat_cnt_a}, 32'(cnt_a_m));
    check("sat_cnt_b", {28'b0, sat_cnt_b}, 32'(cnt_b_m));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sat_clr = 1'b0; x_in = '0;
    #12;
    check("rst_out_valid", {31'b0, out_valid_a}, 32'd0);
    check("rst_xq",        {28'b0, xq_a},        32'd0);
    check("rst_sat",       {31'b0, sat_a},       32'd0);
    check("rst_sat_cnt",   {16'b0, sat_cnt_a},   32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", {31'b0, in_ready_a}, 32'd1);

    // Latency: out_valid rises two cycles after the accepting cycle.
    cycle(1'b1, 48, 1'b1, 1'b0);
    check("lat_1cyc_valid", {31'b0, out_valid_a}, 32'd0);
    cycle(1'b0, 0, 1'b0, 1'b0);
    check("lat_2cyc_valid", {31'b0, out_valid_a}, 32'd1);
    check("lat_xq",         {28'b0, xq_a},        32'd3);
    check("lat_sat",        {31'b0, sat_a},       32'd0);
    cycle(1'b0, 0, 1'b1, 1'b0);

    // Rounding difference and the most negative input.
    cycle(1'b1, 24, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0);
    check("round_24", {28'b0, xq_a}, ROUND ? 32'd2 : 32'd1);
    cycle(1'b1, -128, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 0, 1'b1, 1'b0);

    // Positive full scale: saturates only when rounding pushes it to 8.
    cycle(1'b1, 127, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0);
    check("max_xq",  {28'b0, xq_a},  32'd7);
    check("max_sat", {31'b0, sat_a}, {31'b0, ROUND});
    cycle(1'b0, 0, 1'b1, 1'b0);
    check("max_sat_cnt", {16'b0, sat_cnt_a}, {31'b0, ROUND});

    // Backpressure: two samples held, third stalls, then drains in order.
    cycle(1'b1, 48, 1'b0, 1'b0);
    cycle(1'b1, 32, 1'b0, 1'b0);
    check("bp_second_accept", {31'b0, accepted}, 32'd1);
    repeat (5) begin
      cycle(1'b1, 16, 1'b0, 1'b0);
      check("bp_stall",   {31'b0, accepted},    32'd0);
      check("bp_xq_hold", {28'b0, xq_a},        32'd3);
      check("bp_valid",   {31'b0, out_valid_a}, 32'd1);
    end
    cycle(1'b1, 16, 1'b1, 1'b0);
    check("bp_release_accept", {31'b0, accepted}, 32'd1);
    repeat (3) cycle(1'b0, 0, 1'b1, 1'b0);
    check("bp_drain", 32'(q.size()), 32'd0);

    // Counter saturation and clear-wins on instance b.
    cycle(1'b0, 0, 1'b1, 1'b1);
    repeat (20) cycle(1'b1, 127, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, 0, 1'b1, 1'b0);
    check("cnt_stick", {28'b0, sat_cnt_b}, 32'd15);
    cycle(1'b1, 127, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b1);
    check("cnt_clear_wins", {28'b0, sat_cnt_b}, 32'd0);

    // Asynchronous reset with both stages full.
    cycle(1'b1, 127, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, 0, 1'b1, 1'b0);
    check("pre_rst_cnt", {28'b0, sat_cnt_b}, 32'd1);
    cycle(1'b1, 48, 1'b0, 1'b0);
    cycle(1'b1, 32, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("arst_valid_a", {31'b0, out_valid_a}, 32'd0);
    check("arst_valid_b", {31'b0, out_valid_b}, 32'd0);
    check("arst_cnt_b",   {28'b0, sat_cnt_b},   32'd0);
    check("arst_xq",      {28'b0, xq_a},        32'd0);
    #3;
    rst = 1'b0;
    q.delete();
    cnt_a_m = 0;
    cnt_b_m = 0;
    @(posedge clk);
    #1;
    repeat (4) cycle(1'b0, 0, 1'b1, 1'b0);

    // Random traffic against the model.
    repeat (400) begin
      cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)) - 128,
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
    end
    repeat (4) cycle(1'b0, 0, 1'b1, 1'b0);
    check("final_drain", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
